rs_mul_gen: RTL and testbench
=============================

RS_MUL_GEN -- requirements
Module: rs_mul_gen

Interface
REQ-001 SHALL have parameter ENT_NUM, default 4: entry count, power of two, 2..16.
REQ-002 SHALL have parameter WB_NUM, default 7: number of writeback/wakeup buses.
REQ-003 SHALL have one clock and a synchronous, active-high reset, ports clk and reset; all other ports follow.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 we1/we2  in  1  allocation strobes.
REQ-007 waddr1/waddr2  in  log2(ENT_NUM)  target entries.
REQ-008 wsrc1_k/wsrc2_k  in  DATA_LEN  operand value, or RRF tag in low RRF_SEL bits when invalid.
REQ-009 wvalid1_k/wvalid2_k, wdstval_k, wspecbit_k, wsrc1_signed_k, wsrc2_signed_k, wsel_lohi_k  in  1  per-port entry fields.
REQ-010 wrrftag_k  in  RRF_SEL; wspectag_k  in  SPECTAG_LEN.
REQ-011 exrslt  in  WB_NUM*DATA_LEN; exdst  in  WB_NUM*RRF_SEL; kill_spec  in  WB_NUM  flattened wakeup buses.
REQ-012 prmiss, prsuccess  in  1; prtag, specfixtag  in  SPECTAG_LEN  branch resolution.
REQ-013 issue_valid  out  1; issue_ack  in  1; issue_addr  out  log2(ENT_NUM); ex_src1/ex_src2  out  DATA_LEN; rrftag, dstval, spectag, specbit, src1_signed, src2_signed, sel_lohi  out  issued entry fields.
REQ-014 busyvec  out  ENT_NUM; free_cnt  out  log2(ENT_NUM)+1.

Function
REQ-015 Allocation on we_k SHALL set busy and load all fields in the next cycle; we1 and we2 to the same address is illegal, and port 1 wins.
REQ-016 A busy, invalid operand SHALL capture exrslt[i] and become valid one cycle after exdst[i] equals its tag with kill_spec[i]=0; the lowest i wins on multiple matches.
REQ-017 An entry SHALL be ready when busy and both operands are valid or resolving this cycle; ex_src SHALL bypass the same-cycle wakeup value.
REQ-018 issue_valid SHALL be high whenever any entry is ready; issue_addr SHALL select it per REQ-030; outputs SHALL be combinational from state.
REQ-019 issue_valid&issue_ack SHALL clear the selected busy bit next cycle; selection SHALL be held stable while issue_valid=1 and issue_ack=0, unless prmiss kills the entry.
REQ-020 An entry allocated at cycle t SHALL be issuable no earlier than t+1.
REQ-021 On prmiss, entries with (spectag & specfixtag)!=0 SHALL clear busy; all specbits SHALL clear; allocations and acks that cycle SHALL be ignored.
REQ-022 On prsuccess, entries with spectag==prtag SHALL clear specbit; specbit output SHALL show the post-clear value; allocation in a prsuccess cycle SHALL still occur.
REQ-023 Issue-clear and allocate to the same entry in one cycle SHALL leave it busy with new contents.
REQ-024 free_cnt SHALL equal ENT_NUM minus popcount(busyvec), registered, consistent with busyvec.

Reset
REQ-025 Reset SHALL zero busyvec, specbits, all entry fields and valids, and age state; free_cnt=ENT_NUM; issue_valid=0.
REQ-026 Reset SHALL dominate all other inputs in the same cycle.

Configuration
REQ-027 Macro RS_MUL_AGE_EN SHALL select the issue policy.
REQ-028 Defined: an ENT_NUM x ENT_NUM age matrix SHALL be updated on allocation, with port 1 older than port 2 in the same cycle.
REQ-029 Undefined: no age storage SHALL exist.
REQ-030 Selection SHALL be oldest ready entry with RS_MUL_AGE_EN, else lowest-index ready entry.

Structure
REQ-031 DATA_LEN, RRF_SEL and SPECTAG_LEN SHALL come from the shared package; a wakeup-bus struct or typedef SHALL live there too.
REQ-032 Per-entry storage and wakeup SHALL be sub-module rs_mul_gen_ent, instantiated ENT_NUM times by generate, containing two WB_NUM-wide source managers.

Verification
REQ-033 Alloc entry 2 with valid operands 5 and 7 -> issue_valid=1, issue_addr=2 next cycle; ack -> busyvec[2]=0, free_cnt=4.
REQ-034 Alloc with src1 tag 9 invalid; exdst[3]=9, exrslt[3]=0x1234, kill_spec[3]=0 -> same-cycle ex_src1=0x1234 and ready.
REQ-035 Same wakeup with kill_spec[3]=1 -> operand stays invalid and no issue.
REQ-036 Entries 0 and 1 spectag 0b01 and 0b10; prmiss with specfixtag 0b10 -> only entry 1 cleared, free_cnt rises by 1.
REQ-037 With RS_MUL_AGE_EN: allocate entry 3 then entry 0, both ready -> issue_addr=3; without the macro -> issue_addr=0.
REQ-038 Hold issue_ack=0 for 3 cycles while a younger entry wakes -> issue_addr unchanged; reset asserted mid-hold -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/rs_mul_gen_pkg.sv
// Shared widths and bus/entry types for the multiplier reservation station.
package rs_mul_gen_pkg;

    localparam int DATA_LEN    = 32;
    localparam int RRF_SEL     = 6;
    localparam int SPECTAG_LEN = 5;

    typedef struct packed {
        logic [DATA_LEN-1:0] rslt;
        logic [RRF_SEL-1:0]  dst;
        logic                kill;
    } wb_t;

    typedef struct packed {
        logic [RRF_SEL-1:0]     rrftag;
        logic                   dstval;
        logic [SPECTAG_LEN-1:0] spectag;
        logic                   specbit;
        logic                   src1_signed;
        logic                   src2_signed;
        logic                   sel_lohi;
    } ent_info_t;

    typedef struct packed {
        logic [DATA_LEN-1:0] src1;
        logic                valid1;
        logic [DATA_LEN-1:0] src2;
        logic                valid2;
        ent_info_t           info;
    } ent_load_t;

    function automatic logic spec_hit(input logic [SPECTAG_LEN-1:0] tag,
                                      input logic [SPECTAG_LEN-1:0] fix);
        return |(tag & fix);
    endfunction

endpackage

// File: rtl/rs_mul_gen_ent.sv
// One reservation-station entry: busy/spec state, operand storage and
// two wakeup source managers snooping every writeback bus.
module rs_mul_gen_ent
    import rs_mul_gen_pkg::*;
#(
    parameter int WB_NUM = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we_i,
    input  ent_load_t              load_i,
    input  wb_t [WB_NUM-1:0]       wb_i,
    input  logic                   clr_i,
    input  logic                   prmiss_i,
    input  logic [SPECTAG_LEN-1:0] specfixtag_i,
    input  logic                   prsuccess_i,
    input  logic [SPECTAG_LEN-1:0] prtag_i,
    output logic                   busy_o,
    output logic                   busy_nxt_o,
    output logic                   ready_o,
    output logic [DATA_LEN-1:0]    src1_o,
    output logic [DATA_LEN-1:0]    src2_o,
    output ent_info_t              info_o
);

    logic                     busy_q, busy_d;
    ent_info_t                info_q, info_d;
    logic [1:0][DATA_LEN-1:0] src_q, src_d, wake_s, byp_s;
    logic [1:0]               valid_q, valid_d, hit_s;
    logic                     spec_clr_s;

    // Operand wakeup: descending scan so the lowest matching bus wins.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            hit_s[s]  = 1'b0;
            wake_s[s] = '0;
            for (int i = WB_NUM-1; i >= 0; i--) begin
                if (!wb_i[i].kill && (wb_i[i].dst == src_q[s][RRF_SEL-1:0])) begin
                    hit_s[s]  = busy_q & ~valid_q[s];
                    wake_s[s] = wb_i[i].rslt;
                end else begin
                    hit_s[s]  = hit_s[s];
                    wake_s[s] = wake_s[s];
                end
            end
            byp_s[s] = hit_s[s] ? wake_s[s] : src_q[s];
        end
    end

    // Next-state: wakeup capture, issue/kill clear, spec resolution, allocation last.
    always_comb begin
        spec_clr_s = prsuccess_i && (info_q.spectag == prtag_i);
        busy_d     = busy_q;
        info_d     = info_q;
        src_d      = src_q;
        valid_d    = valid_q;
        for (int s = 0; s < 2; s++) begin
            if (hit_s[s]) begin
                src_d[s]   = wake_s[s];
                valid_d[s] = 1'b1;
            end else begin
                valid_d[s] = valid_q[s];
            end
        end
        if (clr_i || (prmiss_i && spec_hit(info_q.spectag, specfixtag_i))) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (prmiss_i || spec_clr_s) begin
            info_d.specbit = 1'b0;
        end else begin
            info_d.specbit = info_q.specbit;
        end
        if (we_i) begin
            busy_d     = 1'b1;
            info_d     = load_i.info;
            src_d[0]   = load_i.src1;
            valid_d[0] = load_i.valid1;
            src_d[1]   = load_i.src2;
            valid_d[1] = load_i.valid2;
        end else begin
            busy_d = busy_d;
        end
    end

    // Entry state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            info_q  <= '0;
            src_q   <= '0;
            valid_q <= 2'b00;
        end else begin
            busy_q  <= busy_d;
            info_q  <= info_d;
            src_q   <= src_d;
            valid_q <= valid_d;
        end
    end

    // Issue-facing view; specbit reflects a same-cycle prsuccess clear.
    always_comb begin
        info_o         = info_q;
        info_o.specbit = info_q.specbit & ~spec_clr_s;
    end

    assign busy_o     = busy_q;
    assign busy_nxt_o = busy_d;
    assign ready_o    = busy_q & (valid_q[0] | hit_s[0]) & (valid_q[1] | hit_s[1]);
    assign src1_o     = byp_s[0];
    assign src2_o     = byp_s[1];

endmodule

// File: rtl/rs_mul_gen.sv
// Multiplier reservation station: dual allocation, wakeup, single issue.
// RS_MUL_AGE_EN selects oldest-ready issue; otherwise lowest-index ready.
module rs_mul_gen
    import rs_mul_gen_pkg::*;
#(
    parameter int ENT_NUM = 4,
    parameter int WB_NUM  = 7,
    localparam int AW     = $clog2(ENT_NUM)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we1,
    input  logic                          we2,
    input  logic [AW-1:0]                 waddr1,
    input  logic [AW-1:0]                 waddr2,
    input  logic [DATA_LEN-1:0]           wsrc1_1,
    input  logic [DATA_LEN-1:0]           wsrc2_1,
    input  logic [DATA_LEN-1:0]           wsrc1_2,
    input  logic [DATA_LEN-1:0]           wsrc2_2,
    input  logic                          wvalid1_1,
    input  logic                          wvalid2_1,
    input  logic                          wvalid1_2,
    input  logic                          wvalid2_2,
    input  logic                          wdstval_1,
    input  logic                          wdstval_2,
    input  logic                          wspecbit_1,
    input  logic                          wspecbit_2,
    input  logic                          wsrc1_signed_1,
    input  logic                          wsrc1_signed_2,
    input  logic                          wsrc2_signed_1,
    input  logic                          wsrc2_signed_2,
    input  logic                          wsel_lohi_1,
    input  logic                          wsel_lohi_2,
    input  logic [RRF_SEL-1:0]            wrrftag_1,
    input  logic [RRF_SEL-1:0]            wrrftag_2,
    input  logic [SPECTAG_LEN-1:0]        wspectag_1,
    input  logic [SPECTAG_LEN-1:0]        wspectag_2,
    input  logic [WB_NUM*DATA_LEN-1:0]    exrslt,
    input  logic [WB_NUM*RRF_SEL-1:0]     exdst,
    input  logic [WB_NUM-1:0]             kill_spec,
    input  logic                          prmiss,
    input  logic                          prsuccess,
    input  logic [SPECTAG_LEN-1:0]        prtag,
    input  logic [SPECTAG_LEN-1:0]        specfixtag,
    output logic                          issue_valid,
    input  logic                          issue_ack,
    output logic [AW-1:0]                 issue_addr,
    output logic [DATA_LEN-1:0]           ex_src1,
    output logic [DATA_LEN-1:0]           ex_src2,
    output logic [RRF_SEL-1:0]            rrftag,
    output logic                          dstval,
    output logic [SPECTAG_LEN-1:0]        spectag,
    output logic                          specbit,
    output logic                          src1_signed,
    output logic                          src2_signed,
    output logic                          sel_lohi,
    output logic [ENT_NUM-1:0]            busyvec,
    output logic [AW:0]                   free_cnt
);

    localparam logic [AW:0] ENT_CNT = (AW+1)'(ENT_NUM);

    wb_t [WB_NUM-1:0]    wb_s;
    ent_load_t           load1_s, load2_s;
    logic [ENT_NUM-1:0]  ready_s, busy_s, busy_nxt_s;
    logic [DATA_LEN-1:0] src1_s [ENT_NUM];
    logic [DATA_LEN-1:0] src2_s [ENT_NUM];
    ent_info_t           info_s [ENT_NUM];
    ent_info_t           sel_info_s;
    logic [AW-1:0]       pick_addr_s, sel_addr_s, hold_addr_q, hold_addr_d;
    logic                hold_q, hold_d;
    logic [AW:0]         busy_cnt_s, free_cnt_q, free_cnt_d;
    logic                alloc1_s, alloc2_s, issue_clr_s;

    // Unflatten the writeback buses.
    always_comb begin
        for (int i = 0; i < WB_NUM; i++) begin
            wb_s[i].rslt = exrslt[i*DATA_LEN +: DATA_LEN];
            wb_s[i].dst  = exdst[i*RRF_SEL +: RRF_SEL];
            wb_s[i].kill = kill_spec[i];
        end
    end

    assign load1_s = '{src1: wsrc1_1, valid1: wvalid1_1, src2: wsrc2_1, valid2: wvalid2_1,
                       info: '{rrftag: wrrftag_1, dstval: wdstval_1, spectag: wspectag_1,
                               specbit: wspecbit_1, src1_signed: wsrc1_signed_1,
                               src2_signed: wsrc2_signed_1, sel_lohi: wsel_lohi_1}};
    assign load2_s = '{src1: wsrc1_2, valid1: wvalid1_2, src2: wsrc2_2, valid2: wvalid2_2,
                       info: '{rrftag: wrrftag_2, dstval: wdstval_2, spectag: wspectag_2,
                               specbit: wspecbit_2, src1_signed: wsrc1_signed_2,
                               src2_signed: wsrc2_signed_2, sel_lohi: wsel_lohi_2}};

    // A mispredict squashes allocations and acks of the same cycle.
    assign alloc1_s    = we1 & ~prmiss;
    assign alloc2_s    = we2 & ~prmiss;
    assign issue_clr_s = issue_valid & issue_ack & ~prmiss;

    for (genvar e = 0; e < ENT_NUM; e++) begin : g_ent
        logic      hit1_s, hit2_s;
        ent_load_t load_s;
        assign hit1_s = alloc1_s && (waddr1 == AW'(e));
        assign hit2_s = alloc2_s && (waddr2 == AW'(e));
        assign load_s = hit1_s ? load1_s : load2_s;

        rs_mul_gen_ent #(.WB_NUM(WB_NUM)) u_ent (
            .clk         (clk),
            .reset       (reset),
            .we_i        (hit1_s | hit2_s),
            .load_i      (load_s),
            .wb_i        (wb_s),
            .clr_i       (issue_clr_s && (sel_addr_s == AW'(e))),
            .prmiss_i    (prmiss),
            .specfixtag_i(specfixtag),
            .prsuccess_i (prsuccess),
            .prtag_i     (prtag),
            .busy_o      (busy_s[e]),
            .busy_nxt_o  (busy_nxt_s[e]),
            .ready_o     (ready_s[e]),
            .src1_o      (src1_s[e]),
            .src2_o      (src2_s[e]),
            .info_o      (info_s[e])
        );
    end

`ifdef RS_MUL_AGE_EN
    // age_q[i][j] set means entry i was allocated before entry j.
    logic [ENT_NUM-1:0][ENT_NUM-1:0] age_q, age_d;
    logic                            older_s;

    // Oldest-ready pick: ready and older than every other ready entry.
    always_comb begin
        pick_addr_s = '0;
        older_s     = 1'b0;
        for (int i = ENT_NUM-1; i >= 0; i--) begin
            older_s = ready_s[i];
            for (int j = 0; j < ENT_NUM; j++) begin
                if ((j != i) && ready_s[j] && !age_q[i][j]) begin
                    older_s = 1'b0;
                end else begin
                    older_s = older_s;
                end
            end
            if (older_s) begin
                pick_addr_s = AW'(i);
            end else begin
                pick_addr_s = pick_addr_s;
            end
        end
    end

    // New allocations become youngest; port 2 is younger than port 1.
    always_comb begin
        age_d = age_q;
        if (alloc1_s) begin
            for (int j = 0; j < ENT_NUM; j++) begin
                age_d[waddr1][j] = 1'b0;
                age_d[j][waddr1] = (j != int'(waddr1));
            end
        end else begin
            age_d = age_q;
        end
        if (alloc2_s) begin
            for (int j = 0; j < ENT_NUM; j++) begin
                age_d[waddr2][j] = 1'b0;
                age_d[j][waddr2] = (j != int'(waddr2));
            end
        end else begin
            age_d = age_d;
        end
    end

    // Age matrix register.
    always_ff @(posedge clk) begin
        if (reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    // Lowest-index ready pick.
    always_comb begin
        pick_addr_s = '0;
        for (int i = ENT_NUM-1; i >= 0; i--) begin
            if (ready_s[i]) begin
                pick_addr_s = AW'(i);
            end else begin
                pick_addr_s = pick_addr_s;
            end
        end
    end
`endif

    // Hold an unacknowledged selection while its entry stays ready.
    always_comb begin
        if (hold_q && ready_s[hold_addr_q]) begin
            sel_addr_s = hold_addr_q;
        end else begin
            sel_addr_s = pick_addr_s;
        end
        hold_d      = issue_valid & (~issue_ack | prmiss);
        hold_addr_d = sel_addr_s;
        busy_cnt_s  = '0;
        for (int i = 0; i < ENT_NUM; i++) begin
            busy_cnt_s = busy_cnt_s + {{AW{1'b0}}, busy_nxt_s[i]};
        end
        free_cnt_d = ENT_CNT - busy_cnt_s;
    end

    // Selection hold and free-count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q      <= 1'b0;
            hold_addr_q <= '0;
            free_cnt_q  <= ENT_CNT;
        end else begin
            hold_q      <= hold_d;
            hold_addr_q <= hold_addr_d;
            free_cnt_q  <= free_cnt_d;
        end
    end

    assign sel_info_s  = info_s[sel_addr_s];
    assign issue_valid = |ready_s;
    assign issue_addr  = sel_addr_s;
    assign ex_src1     = src1_s[sel_addr_s];
    assign ex_src2     = src2_s[sel_addr_s];
    assign rrftag      = sel_info_s.rrftag;
    assign dstval      = sel_info_s.dstval;
    assign spectag     = sel_info_s.spectag;
    assign specbit     = sel_info_s.specbit;
    assign src1_signed = sel_info_s.src1_signed;
    assign src2_signed = sel_info_s.src2_signed;
    assign sel_lohi    = sel_info_s.sel_lohi;
    assign busyvec     = busy_s;
    assign free_cnt    = free_cnt_q;

endmodule

// File: tb/tb_rs_mul_gen.sv
// Directed self-checking bench for rs_mul_gen (default ENT_NUM=4, WB_NUM=7).
module tb_rs_mul_gen;
    import rs_mul_gen_pkg::*;

    localparam int ENT_NUM = 4;
    localparam int WB_NUM  = 7;
`ifdef RS_MUL_AGE_EN
    localparam logic [1:0] EXP_PICK = 2'd3;
`else
    localparam logic [1:0] EXP_PICK = 2'd0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic we1, we2;
    logic [1:0] waddr1, waddr2;
    logic [DATA_LEN-1:0] wsrc1_1, wsrc2_1, wsrc1_2, wsrc2_2;
    logic wvalid1_1, wvalid2_1, wvalid1_2, wvalid2_2;
    logic wdstval_1, wdstval_2, wspecbit_1, wspecbit_2;
    logic wsrc1_signed_1, wsrc1_signed_2, wsrc2_signed_1, wsrc2_signed_2;
    logic wsel_lohi_1, wsel_lohi_2;
    logic [RRF_SEL-1:0] wrrftag_1, wrrftag_2;
    logic [SPECTAG_LEN-1:0] wspectag_1, wspectag_2;
    logic [WB_NUM*DATA_LEN-1:0] exrslt;
    logic [WB_NUM*RRF_SEL-1:0] exdst;
    logic [WB_NUM-1:0] kill_spec;
    logic prmiss, prsuccess;
    logic [SPECTAG_LEN-1:0] prtag, specfixtag;
    logic issue_valid, issue_ack;
    logic [1:0] issue_addr;
    logic [DATA_LEN-1:0] ex_src1, ex_src2;
    logic [RRF_SEL-1:0] rrftag;
    logic dstval, specbit, src1_signed, src2_signed, sel_lohi;
    logic [SPECTAG_LEN-1:0] spectag;
    logic [ENT_NUM-1:0] busyvec;
    logic [2:0] free_cnt;

    int n_checks = 0;
    int n_errors = 0;

    rs_mul_gen #(.ENT_NUM(ENT_NUM), .WB_NUM(WB_NUM)) dut (
        .clk(clk), .reset(reset), .we1(we1), .we2(we2),
        .waddr1(waddr1), .waddr2(waddr2),
        .wsrc1_1(wsrc1_1), .wsrc2_1(wsrc2_1), .wsrc1_2(wsrc1_2), .wsrc2_2(wsrc2_2),
        .wvalid1_1(wvalid1_1), .wvalid2_1(wvalid2_1), .wvalid1_2(wvalid1_2), .wvalid2_2(wvalid2_2),
        .wdstval_1(wdstval_1), .wdstval_2(wdstval_2), .wspecbit_1(wspecbit_1), .wspecbit_2(wspecbit_2),
        .wsrc1_signed_1(wsrc1_signed_1), .wsrc1_signed_2(wsrc1_signed_2),
        .wsrc2_signed_1(wsrc2_signed_1), .wsrc2_signed_2(wsrc2_signed_2),
        .wsel_lohi_1(wsel_lohi_1), .wsel_lohi_2(wsel_lohi_2),
        .wrrftag_1(wrrftag_1), .wrrftag_2(wrrftag_2),
        .wspectag_1(wspectag_1), .wspectag_2(wspectag_2),
        .exrslt(exrslt), .exdst(exdst), .kill_spec(kill_spec),
        .prmiss(prmiss), .prsuccess(prsuccess), .prtag(prtag), .specfixtag(specfixtag),
        .issue_valid(issue_valid), .issue_ack(issue_ack), .issue_addr(issue_addr),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .rrftag(rrftag), .dstval(dstval),
        .spectag(spectag), .specbit(specbit), .src1_signed(src1_signed),
        .src2_signed(src2_signed), .sel_lohi(sel_lohi),
        .busyvec(busyvec), .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we1 = 1'b0; we2 = 1'b0; waddr1 = 2'd0; waddr2 = 2'd0;
        wsrc1_1 = '0; wsrc2_1 = '0; wsrc1_2 = '0; wsrc2_2 = '0;
        wvalid1_1 = 1'b0; wvalid2_1 = 1'b0; wvalid1_2 = 1'b0; wvalid2_2 = 1'b0;
        wdstval_1 = 1'b0; wdstval_2 = 1'b0; wspecbit_1 = 1'b0; wspecbit_2 = 1'b0;
        wsrc1_signed_1 = 1'b0; wsrc1_signed_2 = 1'b0; wsrc2_signed_1 = 1'b0; wsrc2_signed_2 = 1'b0;
        wsel_lohi_1 = 1'b0; wsel_lohi_2 = 1'b0;
        wrrftag_1 = '0; wrrftag_2 = '0; wspectag_1 = '0; wspectag_2 = '0;
        exrslt = '0; exdst = '0; kill_spec = {WB_NUM{1'b1}};
        prmiss = 1'b0; prsuccess = 1'b0; prtag = '0; specfixtag = '0;
        issue_ack = 1'b0;
    endtask

    task automatic alloc1(input logic [1:0] a, input logic [31:0] s1, input logic v1,
                          input logic [31:0] s2, input logic v2, input logic [5:0] tag,
                          input logic [4:0] st, input logic sb);
        we1 = 1'b1; waddr1 = a; wsrc1_1 = s1; wvalid1_1 = v1; wsrc2_1 = s2; wvalid2_1 = v2;
        wrrftag_1 = tag; wspectag_1 = st; wspecbit_1 = sb; wdstval_1 = 1'b1;
    endtask

    task automatic alloc2(input logic [1:0] a, input logic [31:0] s1, input logic v1,
                          input logic [31:0] s2, input logic v2, input logic [5:0] tag,
                          input logic [4:0] st, input logic sb);
        we2 = 1'b1; waddr2 = a; wsrc1_2 = s1; wvalid1_2 = v1; wsrc2_2 = s2; wvalid2_2 = v2;
        wrrftag_2 = tag; wspectag_2 = st; wspecbit_2 = sb; wdstval_2 = 1'b1;
    endtask

    task automatic wake(input int bus, input logic [5:0] dst, input logic [31:0] val, input logic kill);
        exdst[bus*RRF_SEL +: RRF_SEL]    = dst;
        exrslt[bus*DATA_LEN +: DATA_LEN] = val;
        kill_spec[bus]                   = kill;
    endtask

    task automatic ack_one();
        issue_ack = 1'b1;
        step();
        issue_ack = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        step(); step();
        check_eq("rst_busyvec", 64'(busyvec), 64'h0);
        check_eq("rst_free_cnt", 64'(free_cnt), 64'd4);
        check_eq("rst_issue_valid", 64'(issue_valid), 64'd0);
        reset = 1'b0;

        // Basic allocate / issue / ack on entry 2
        alloc1(2'd2, 32'd5, 1'b1, 32'd7, 1'b1, 6'd3, 5'd0, 1'b0);
        #1 check_eq("alloc_not_same_cycle", 64'(issue_valid), 64'd0);
        step(); idle_inputs();
        #1;
        check_eq("basic_issue_valid", 64'(issue_valid), 64'd1);
        check_eq("basic_issue_addr", 64'(issue_addr), 64'd2);
        check_eq("basic_ex_src1", 64'(ex_src1), 64'd5);
        check_eq("basic_ex_src2", 64'(ex_src2), 64'd7);
        check_eq("basic_rrftag", 64'(rrftag), 64'd3);
        check_eq("basic_busyvec", 64'(busyvec), 64'h4);
        check_eq("basic_free_cnt", 64'(free_cnt), 64'd3);
        ack_one();
        check_eq("ack_busyvec", 64'(busyvec), 64'h0);
        check_eq("ack_free_cnt", 64'(free_cnt), 64'd4);
        check_eq("ack_issue_valid", 64'(issue_valid), 64'd0);

        // Wakeup: killed bus ignored, live bus bypassed, lowest bus wins
        alloc1(2'd1, 32'd9, 1'b0, 32'd2, 1'b1, 6'd4, 5'd0, 1'b0);
        step(); idle_inputs();
        wake(3, 6'd9, 32'h1234, 1'b1);
        #1 check_eq("kill_no_ready", 64'(issue_valid), 64'd0);
        step();
        check_eq("kill_stays_invalid", 64'(issue_valid), 64'd0);
        wake(3, 6'd9, 32'h1234, 1'b0);
        wake(5, 6'd9, 32'hBEEF, 1'b0);
        #1;
        check_eq("wake_ready", 64'(issue_valid), 64'd1);
        check_eq("wake_addr", 64'(issue_addr), 64'd1);
        check_eq("wake_bypass_src1", 64'(ex_src1), 64'h1234);
        step(); idle_inputs();
        #1 check_eq("wake_captured_src1", 64'(ex_src1), 64'h1234);
        ack_one();
        check_eq("wake_drained", 64'(busyvec), 64'h0);

        // Speculation: prsuccess clears specbit, prmiss kills matching entry only
        alloc1(2'd0, 32'd1, 1'b1, 32'd1, 1'b1, 6'd1, 5'b00001, 1'b1);
        alloc2(2'd1, 32'd2, 1'b1, 32'd2, 1'b1, 6'd2, 5'b00010, 1'b1);
        step(); idle_inputs();
        #1;
        check_eq("spec_busyvec", 64'(busyvec), 64'h3);
        check_eq("spec_free_cnt", 64'(free_cnt), 64'd2);
        check_eq("spec_pick", 64'(issue_addr), 64'd0);
        check_eq("spec_specbit_set", 64'(specbit), 64'd1);
        prsuccess = 1'b1; prtag = 5'b00001;
        #1 check_eq("prsuccess_specbit_clear", 64'(specbit), 64'd0);
        step(); idle_inputs();
        prmiss = 1'b1; specfixtag = 5'b00010;
        alloc1(2'd3, 32'd8, 1'b1, 32'd8, 1'b1, 6'd8, 5'd0, 1'b0);
        issue_ack = 1'b1;
        step(); idle_inputs();
        #1;
        check_eq("prmiss_busyvec", 64'(busyvec), 64'h1);
        check_eq("prmiss_free_cnt", 64'(free_cnt), 64'd3);
        check_eq("prmiss_addr", 64'(issue_addr), 64'd0);
        check_eq("prmiss_specbit", 64'(specbit), 64'd0);
        ack_one();
        check_eq("spec_drained", 64'(free_cnt), 64'd4);

        // Policy: entry 3 older than entry 0, both woken together
        alloc1(2'd3, 32'd4, 1'b0, 32'd1, 1'b1, 6'd5, 5'd0, 1'b0);
        step(); idle_inputs();
        alloc1(2'd0, 32'd4, 1'b0, 32'd1, 1'b1, 6'd6, 5'd0, 1'b0);
        step(); idle_inputs();
        wake(0, 6'd4, 32'h44, 1'b0);
        #1;
        check_eq("policy_valid", 64'(issue_valid), 64'd1);
        check_eq("policy_addr", 64'(issue_addr), 64'(EXP_PICK));
        step(); idle_inputs();
        ack_one();
        ack_one();
        check_eq("policy_drained", 64'(busyvec), 64'h0);

        // Hold selection while a younger lower-index entry wakes, then reset mid-hold
        alloc1(2'd2, 32'h22, 1'b1, 32'h33, 1'b1, 6'd7, 5'd0, 1'b1);
        step(); idle_inputs();
        alloc1(2'd1, 32'd6, 1'b0, 32'd1, 1'b1, 6'd9, 5'd0, 1'b0);
        step(); idle_inputs();
        wake(0, 6'd6, 32'h66, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1 check_eq("hold_addr", 64'(issue_addr), 64'd2);
            step();
            idle_inputs();
        end
        check_eq("hold_busyvec", 64'(busyvec), 64'h6);
        reset = 1'b1;
        alloc1(2'd3, 32'd1, 1'b1, 32'd1, 1'b1, 6'd1, 5'd0, 1'b1);
        issue_ack = 1'b1;
        step(); idle_inputs();
        check_eq("rst2_issue_valid", 64'(issue_valid), 64'd0);
        check_eq("rst2_busyvec", 64'(busyvec), 64'h0);
        check_eq("rst2_free_cnt", 64'(free_cnt), 64'd4);
        check_eq("rst2_issue_addr", 64'(issue_addr), 64'd0);
        check_eq("rst2_ex_src1", 64'(ex_src1), 64'd0);
        check_eq("rst2_specbit", 64'(specbit), 64'd0);
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
